// File: rtl/beam_threshold_receiver_if.sv
// Threshold load stream from the WISHBONE threshold block to the DSP-side receiver.
// Two 18-bit lanes share one word strobe and one commit strobe. Each strobe is
// duplicated per lane, and the two copies always match.
interface beam_threshold_receiver_if #(
   parameter int THBITS = 18
);
   logic [2*THBITS-1:0] thresh_dat;
   logic [1:0]          thresh_wr;
   logic [1:0]          thresh_update;

   modport master (
      output thresh_dat,
      output thresh_wr,
      output thresh_update
   );

   modport slave (
      input  thresh_dat,
      input  thresh_wr,
      input  thresh_update
   );
endinterface

// File: rtl/beam_threshold_receiver.sv
// Receiver for the beam threshold load stream.
// A load arrives as NWORDS two-lane words. Each pair of beams gets a delta word
// (trig - sub) followed by its trigger word, and the pairs arrive highest first.
// The words land in a shadow bank. On an update with a complete load, the shadow
// bank is copied into the active bank at once, and the subthreshold is rebuilt
// as trig - delta.
module beam_threshold_receiver #(
   parameter  int NBEAMS     = 46,
   parameter  int THBITS     = 18,
   localparam int NDUALBEAMS = NBEAMS / 2 + NBEAMS % 2,
   localparam int NWORDS     = 2 * NDUALBEAMS,
   localparam int CW         = $clog2(NWORDS + 1)
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   beam_threshold_receiver_if.slave   thr,
   input  logic                       err_clr_i,
   output logic [NBEAMS*THBITS-1:0]   trig_thresh_o,
   output logic [NBEAMS*THBITS-1:0]   sub_thresh_o,
   output logic                       thresh_valid_o,
   output logic                       update_done_o,
   output logic [CW-1:0]              load_count_o,
   output logic                       short_err_o,
   output logic                       ovf_err_o
);

   localparam logic [CW-1:0] NWORDS_C = CW'(NWORDS);

   logic          wr_stb;
   logic          upd_stb;
   logic          unused_strobe_copies;

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [CW-1:0] count_after_wr;
   logic          wr_accept;
   logic          ovf_evt;
   logic          commit;
   logic          short_evt;

   logic          valid_reg;
   logic          done_reg;
   logic          short_err_reg;
   logic          ovf_err_reg;

   // The lanes always carry identical strobes, so only lane 0 is looked at.
   assign wr_stb               = thr.thresh_wr[0];
   assign upd_stb              = thr.thresh_update[0];
   assign unused_strobe_copies = thr.thresh_wr[1] ^ thr.thresh_update[1];

   // A same-cycle write is absorbed before the update checks the count.
   // As a result, the last word can arrive together with its commit.
   always_comb begin
      wr_accept      = wr_stb && (count_reg < NWORDS_C);
      ovf_evt        = wr_stb && !wr_accept;
      count_after_wr = wr_accept ? count_reg + CW'(1) : count_reg;
      commit         = upd_stb && (count_after_wr == NWORDS_C);
      short_evt      = upd_stb && !commit;
      count_next     = upd_stb ? '0 : count_after_wr;
   end

   // Load counter, commit status and sticky errors. A new error beats a clear.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         count_reg     <= '0;
         valid_reg     <= 1'b0;
         done_reg      <= 1'b0;
         short_err_reg <= 1'b0;
         ovf_err_reg   <= 1'b0;
      end else begin
         count_reg     <= count_next;
         valid_reg     <= valid_reg | commit;
         done_reg      <= commit;
         short_err_reg <= short_evt | (short_err_reg & ~err_clr_i);
         ovf_err_reg   <= ovf_evt   | (ovf_err_reg   & ~err_clr_i);
      end
   end

   assign load_count_o   = count_reg;
   assign thresh_valid_o = valid_reg;
   assign update_done_o  = done_reg;
   assign short_err_o    = short_err_reg;
   assign ovf_err_o      = ovf_err_reg;

   // One slice per output beam. Beam b belongs to pair b/2 and lane b%2.
   // For an odd beam count, the spare lane-1 slot of the last pair has no slice.
   // Its word is accepted and counted but never stored.
   genvar gi;
   generate
      for (gi = 0; gi < NBEAMS; gi++) begin : g_beam
         localparam int            PAIR_IDX = gi / 2;
         localparam int            LANE     = gi % 2;
         localparam logic [CW-2:0] SLOT     = (CW-1)'(NDUALBEAMS - 1 - PAIR_IDX);

         logic              slot_hit;
         logic              delta_we;
         logic              trig_we;
         logic [THBITS-1:0] lane_word;
         logic [THBITS-1:0] shadow_trig_reg;
         logic [THBITS-1:0] shadow_delta_reg;
         logic [THBITS-1:0] trig_src;
         logic [THBITS-1:0] delta_src;
         logic [THBITS-1:0] act_trig_reg;
         logic [THBITS-1:0] act_sub_reg;

         assign lane_word = thr.thresh_dat[LANE*THBITS +: THBITS];
         assign slot_hit  = wr_accept && (count_reg[CW-1:1] == SLOT);
         assign delta_we  = slot_hit && !count_reg[0];
         assign trig_we   = slot_hit &&  count_reg[0];

         // A word written in the commit cycle is forwarded straight to the active bank.
         assign trig_src  = trig_we  ? lane_word : shadow_trig_reg;
         assign delta_src = delta_we ? lane_word : shadow_delta_reg;

         // Shadow capture: overwritten by index, kept across commits and errors.
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               shadow_trig_reg  <= '0;
               shadow_delta_reg <= '0;
            end else begin
               if (delta_we) shadow_delta_reg <= lane_word;
               if (trig_we)  shadow_trig_reg  <= lane_word;
            end
         end

         // Active bank: atomic copy on commit; the subtraction wraps modulo 2^THBITS.
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               act_trig_reg <= '0;
               act_sub_reg  <= '0;
            end else if (commit) begin
               act_trig_reg <= trig_src;
               act_sub_reg  <= trig_src - delta_src;
            end
         end

         assign trig_thresh_o[gi*THBITS +: THBITS] = act_trig_reg;
         assign sub_thresh_o[gi*THBITS +: THBITS]  = act_sub_reg;
      end
   endgenerate

endmodule

// File: tb/tb_beam_threshold_receiver.sv
// Directed bench for beam_threshold_receiver.
// It runs a 46-beam and a 45-beam instance side by side from one shared stream.
module tb_beam_threshold_receiver;

   logic aclk = 1'b0;
   logic aresetn;
   logic err_clr;

   logic [46*18-1:0] trig0, sub0;
   logic [45*18-1:0] trig1, sub1;
   logic             valid0, done0, short0, ovf0;
   logic             valid1, done1, short1, ovf1;
   logic [5:0]       cnt0, cnt1;

   int n_total = 0;
   int n_bad   = 0;

   // Per-pair stimulus words: tN = trigger, dN = delta, N = lane.
   logic [17:0] t0 [23];
   logic [17:0] d0 [23];
   logic [17:0] t1 [23];
   logic [17:0] d1 [23];

   beam_threshold_receiver_if th_if ();

   always #5 aclk = ~aclk;

   beam_threshold_receiver #(.NBEAMS(46), .THBITS(18)) dut0 (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .thr            (th_if),
      .err_clr_i      (err_clr),
      .trig_thresh_o  (trig0),
      .sub_thresh_o   (sub0),
      .thresh_valid_o (valid0),
      .update_done_o  (done0),
      .load_count_o   (cnt0),
      .short_err_o    (short0),
      .ovf_err_o      (ovf0)
   );

   beam_threshold_receiver #(.NBEAMS(45), .THBITS(18)) dut1 (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .thr            (th_if),
      .err_clr_i      (err_clr),
      .trig_thresh_o  (trig1),
      .sub_thresh_o   (sub1),
      .thresh_valid_o (valid1),
      .update_done_o  (done1),
      .load_count_o   (cnt1),
      .short_err_o    (short1),
      .ovf_err_o      (ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] b46(input logic [46*18-1:0] v, input int b);
      return 32'(v[b*18 +: 18]);
   endfunction

   function automatic logic [31:0] b45(input logic [45*18-1:0] v, input int b);
      return 32'(v[b*18 +: 18]);
   endfunction

   task automatic fill(input logic [17:0] tb0, input logic [17:0] db0,
                       input logic [17:0] tb1, input logic [17:0] db1);
      for (int p = 0; p < 23; p++) begin
         t0[p] = tb0 + 18'(p);
         d0[p] = db0 + 18'(p);
         t1[p] = tb1 + 18'(p);
         d1[p] = db1 + 18'(p);
      end
   endtask

   task automatic send_word(input logic [17:0] l0, input logic [17:0] l1, input logic with_upd);
      @(negedge aclk);
      th_if.thresh_dat    = {l1, l0};
      th_if.thresh_wr     = 2'b11;
      th_if.thresh_update = with_upd ? 2'b11 : 2'b00;
      @(negedge aclk);
      th_if.thresh_wr     = 2'b00;
      th_if.thresh_update = 2'b00;
   endtask

   // Words 0..n-1 of the current stimulus, pair 22 first, delta before trigger.
   task automatic send_words(input int n);
      for (int i = 0; i < n; i++) begin
         int p;
         p = 22 - i / 2;
         if (i % 2 == 0) send_word(d0[p], d1[p], 1'b0);
         else            send_word(t0[p], t1[p], 1'b0);
      end
      $display("load: sent %0d words, count=%0d", n, cnt0);
   endtask

   task automatic send_update(input logic with_clr);
      @(negedge aclk);
      th_if.thresh_update = 2'b11;
      err_clr             = with_clr;
      @(negedge aclk);
      th_if.thresh_update = 2'b00;
      err_clr             = 1'b0;
      $display("update: done=%0d valid=%0d short=%0d count=%0d", done0, valid0, short0, cnt0);
   endtask

   task automatic pulse_clr();
      @(negedge aclk);
      err_clr = 1'b1;
      @(negedge aclk);
      err_clr = 1'b0;
      $display("err_clr: short=%0d ovf=%0d", short0, ovf0);
   endtask

   initial begin
      aresetn             = 1'b0;
      err_clr             = 1'b0;
      th_if.thresh_dat    = '0;
      th_if.thresh_wr     = 2'b00;
      th_if.thresh_update = 2'b00;
      repeat (3) @(negedge aclk);

      // Reset state
      chk("rst_trig_any", 32'(|trig0), 0);
      chk("rst_sub_any",  32'(|sub0), 0);
      chk("rst_valid",    32'(valid0), 0);
      chk("rst_done",     32'(done0), 0);
      chk("rst_count",    32'(cnt0), 0);
      chk("rst_errs",     32'({short0, ovf0}), 0);
      aresetn = 1'b1;

      // 1 Full load
      fill(18'h01000, 18'h00010, 18'h02000, 18'h00020);
      send_words(46);
      chk("t1_count46",     32'(cnt0), 46);
      chk("t1_count46_odd", 32'(cnt1), 46);
      chk("t1_pre_beam0",   b46(trig0, 0), 0);
      chk("t1_pre_valid",   32'(valid0), 0);
      send_update(1'b0);
      chk("t1_done",  32'(done0), 1);
      chk("t1_valid", 32'(valid0), 1);
      chk("t1_count", 32'(cnt0), 0);
      chk("t1_b0_trig",  b46(trig0, 0),  'h01000);
      chk("t1_b0_sub",   b46(sub0, 0),   'h00FF0);
      chk("t1_b1_trig",  b46(trig0, 1),  'h02000);
      chk("t1_b1_sub",   b46(sub0, 1),   'h01FE0);
      chk("t1_b44_trig", b46(trig0, 44), 'h01016);
      chk("t1_b45_trig", b46(trig0, 45), 'h02016);
      chk("t1_b45_sub",  b46(sub0, 45),  'h01FE0);
      for (int b = 0; b < 46; b++) begin
         chk($sformatf("t1_trig_b%0d", b), b46(trig0, b),
             (b % 2 == 0) ? 32'h1000 + 32'(b / 2) : 32'h2000 + 32'(b / 2));
         chk($sformatf("t1_sub_b%0d", b), b46(sub0, b),
             (b % 2 == 0) ? 32'h0FF0 : 32'h1FE0);
      end
      // 7 Odd beam count: beam 44 comes from pair 22 lane 0
      chk("t7_b44_trig", b45(trig1, 44), 'h01016);
      chk("t7_b44_sub",  b45(sub1, 44),  'h00FF0);
      chk("t7_b43_trig", b45(trig1, 43), 'h02015);
      chk("t7_valid",    32'(valid1), 1);
      @(negedge aclk);
      chk("t1_done_one_cycle", 32'(done0), 0);

      // 2 Short load
      fill(18'h03000, 18'h00000, 18'h03000, 18'h00000);
      send_words(45);
      send_update(1'b0);
      chk("t2_done",   32'(done0), 0);
      chk("t2_short",  32'(short0), 1);
      chk("t2_count",  32'(cnt0), 0);
      chk("t2_b0_kept", b46(trig0, 0), 'h01000);
      chk("t2_b45_kept", b46(sub0, 45), 'h01FE0);
      send_words(10);
      send_update(1'b1);
      chk("t2_err_wins_clr", 32'(short0), 1);
      pulse_clr();
      chk("t2_cleared", 32'(short0), 0);

      // 3 Overflow
      fill(18'h05000, 18'h00040, 18'h06000, 18'h00080);
      send_words(46);
      chk("t3_ovf_pre", 32'(ovf0), 0);
      send_word(18'h3FFFF, 18'h3FFFF, 1'b0);
      chk("t3_ovf",   32'(ovf0), 1);
      chk("t3_count", 32'(cnt0), 46);
      send_update(1'b0);
      chk("t3_done",    32'(done0), 1);
      chk("t3_short",   32'(short0), 0);
      chk("t3_b0_trig", b46(trig0, 0), 'h05000);
      chk("t3_b0_sub",  b46(sub0, 0),  'h04FC0);
      chk("t3_b1_sub",  b46(sub0, 1),  'h05F80);
      chk("t3_b40_trig", b46(trig0, 40), 'h05014);
      pulse_clr();
      chk("t3_ovf_cleared", 32'(ovf0), 0);

      // 4 Wrap
      fill(18'h01000, 18'h00010, 18'h02000, 18'h00020);
      t0[0] = 18'h00002; d0[0] = 18'h00005;
      t1[0] = 18'h3FFFF; d1[0] = 18'h00000;
      send_words(46);
      send_update(1'b0);
      chk("t4_b0_trig", b46(trig0, 0), 'h00002);
      chk("t4_b0_sub",  b46(sub0, 0),  'h3FFFD);
      chk("t4_b1_sub",  b46(sub0, 1),  'h3FFFF);
      chk("t4_odd_b0_sub", b45(sub1, 0), 'h3FFFD);

      // 5 Last word together with the update
      t0[0] = 18'h0ABCD; d0[0] = 18'h00BCD;
      t1[0] = 18'h12345; d1[0] = 18'h00345;
      send_words(45);
      chk("t5_count45", 32'(cnt0), 45);
      chk("t5_b0_old",  b46(trig0, 0), 'h00002);
      send_word(t0[0], t1[0], 1'b1);
      $display("update+write: done=%0d count=%0d", done0, cnt0);
      chk("t5_done",    32'(done0), 1);
      chk("t5_short",   32'(short0), 0);
      chk("t5_ovf",     32'(ovf0), 0);
      chk("t5_count",   32'(cnt0), 0);
      chk("t5_b0_trig", b46(trig0, 0), 'h0ABCD);
      chk("t5_b0_sub",  b46(sub0, 0),  'h0A000);
      chk("t5_b1_trig", b46(trig0, 1), 'h12345);
      chk("t5_b1_sub",  b46(sub0, 1),  'h12000);

      // 6 Reset mid-load, then a full reload
      send_words(20);
      chk("t6_count20", 32'(cnt0), 20);
      aresetn = 1'b0;
      #1;
      $display("reset asserted: valid=%0d count=%0d", valid0, cnt0);
      chk("t6_trig_any", 32'(|trig0), 0);
      chk("t6_sub_any",  32'(|sub0), 0);
      chk("t6_odd_any",  32'(|{trig1, sub1}), 0);
      chk("t6_valid",    32'(valid0), 0);
      chk("t6_count",    32'(cnt0), 0);
      @(negedge aclk);
      aresetn = 1'b1;
      fill(18'h01000, 18'h00010, 18'h02000, 18'h00020);
      send_words(46);
      send_update(1'b0);
      chk("t6_valid_again", 32'(valid0), 1);
      chk("t6_b0_trig",  b46(trig0, 0),  'h01000);
      chk("t6_b0_sub",   b46(sub0, 0),   'h00FF0);
      chk("t6_b45_trig", b46(trig0, 45), 'h02016);
      chk("t6_odd_b44",  b45(trig1, 44), 'h01016);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
